msu_data_buf: RTL and testbench
===============================

// Module: msu_data_buf
// PURPOSE
//   16 KiB simple dual-port byte buffer for the MSU-1 data stream.
//   Port A is the fill port, written by the MCU/loader (pgm_* path).
//   Port B is a registered read port feeding the MSU data register ($2001 read path).
//   Both ports share one clock. Intended to map onto block RAM.
// PARAMETERS
//   ADDR_W   14   address width, both ports (depth = 2**ADDR_W = 16384)
//   DATA_W   8    data width, both ports
// PORTS
//   clkin   in   1       sole clock; all logic on the rising edge
//   rst_n   in   1       synchronous reset, active low
//   wea     in   1       port A write enable, active high
//   addra   in   ADDR_W  port A write address
//   dina    in   DATA_W  port A write data
//   addrb   in   ADDR_W  port B read address
//   doutb   out  DATA_W  port B registered read data
// BEHAVIOUR
//   - Interface: one clock, clkin; reset rst_n is synchronous and active low.
//   - Storage: mem[0 .. 2**ADDR_W-1] of DATA_W bits.
//     Simulation power-up contents are all 0x00.
//     rst_n does NOT clear the array.
//   - Write: at a clkin edge with rst_n=1 and wea=1, mem[addra] <= dina.
//     Writes are ignored while rst_n=0.
//   - Read: at every clkin edge with rst_n=1, doutb <= mem[addrb].
//     Latency is 1 cycle: an address presented before edge N is visible on doutb after edge N.
//     doutb holds its value until the next edge.
//   - Read-during-write, same address: read-first.
//     doutb returns the old contents at edge N.
//     The new data is visible from edge N+1 when addrb is held.
//   - Read and write at different addresses in the same cycle are fully independent.
//   - Reset: while rst_n=0 at an edge, doutb <= 0x00.
//     The first valid read occurs at the first edge with rst_n=1.
//     A write asserted in the same cycle that reset is released (rst_n=1) is performed.
//   - Addresses are exactly ADDR_W bits; there is no wrap logic inside the block.
//     Address 0x3FFF is the last byte.
//     The caller increments addrb modulo 2**ADDR_W, so 0x3FFF+1 reads 0x0000.
//   - No X propagation: addresses are always in range, so every read returns defined data.
//   - Purely synchronous; no combinational path from any input to doutb.
// TESTING
//   1. Reset: rst_n=0 for 3 cycles with wea=1, addra=0x0010, dina=0xFF.
//      -> doutb=0x00 throughout; after release, reading 0x0010 returns 0x00 (write blocked).
//   2. Basic write/read: write 0xA5 @0x0000, then addrb=0x0000.
//      -> doutb=0xA5 one edge after addrb applied.
//   3. Boundary: write 0x5A @0x3FFF and 0x11 @0x0000; read 0x3FFF, then 0x0000.
//      -> 0x5A, then 0x11 on consecutive cycles.
//   4. Read-first: mem[0x0123]=0x22; same cycle wea=1, addra=addrb=0x0123, dina=0x33.
//      -> doutb=0x22 after that edge, 0x33 after the next edge.
//   5. Streaming: fill 0x0000-0x3FFF with (addr ^ addr>>8) & 0xFF; read back incrementing addrb every cycle.
//      -> every byte matches with 1-cycle latency; wrap 0x3FFF->0x0000 is seamless.
//   6. Concurrent ports: write an incrementing pattern at addra while reading a disjoint region at addrb.
//      -> read data is unaffected by the concurrent writes.

Source files
------------

// File: rtl/msu_data_buf_if.sv
// Port bundle for the MSU-1 data buffer.
// Port A (wea/addra/dina) is the fill path from the MCU/loader.
// Port B (addrb/doutb) is the registered read path to the $2001 data register.
//
// Port timing: there is no valid/ready handshake.
//   A write is taken at any rising clkin edge where wea=1 and rst_n=1.
//   A read address presented before edge N has its data on doutb after edge N.
//   doutb holds that data until the next edge.
interface msu_data_buf_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] doutb;

  // Loader/consumer side: drives both ports' control and samples read data.
  modport master (
    output wea,
    output addra,
    output dina,
    output addrb,
    input  doutb
  );

  // Buffer side.
  modport slave (
    input  wea,
    input  addra,
    input  dina,
    input  addrb,
    output doutb
  );
endinterface

// File: rtl/msu_data_buf.sv
// MSU-1 data stream buffer: 2**ADDR_W x DATA_W simple dual-port RAM.
// Port A writes, port B reads through a single output register.
// Same-address read and write in one cycle is read-first (old data returned).
// Reset clears only the output register, never the array.
module msu_data_buf #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic           clkin,
  input  logic           rst_n,
  msu_data_buf_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Storage array; power-up contents are all zero (also serves as a block RAM
  // init image). Left without a reset so it maps onto block RAM.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1] = '{default: '0};
  logic [DATA_W-1:0] r_doutb;

  // Port A write; blocked while reset is asserted.
  always_ff @(posedge clkin) begin
    if (rst_n && bus.wea) begin
      r_mem[bus.addra] <= bus.dina;
    end
  end

  // Port B registered read. Sampling the array with a non-blocking read in
  // the same edge as the write gives read-first behaviour on address collisions.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      r_doutb <= '0;
    end else begin
      r_doutb <= r_mem[bus.addrb];
    end
  end

  assign bus.doutb = r_doutb;

endmodule

// File: tb/tb_msu_data_buf.sv
// Bench for msu_data_buf: directed scenarios plus random traffic, checked
// against a plain byte-array model through an expected-value queue.
module tb_msu_data_buf;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  // ---------------- clock / reset ----------------
  logic clkin;
  logic rst_n;

  initial begin
    clkin = 1'b0;
    forever #5 clkin = ~clkin;
  end

  msu_data_buf_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  msu_data_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clkin (clkin),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] model_mem [0:DEPTH-1];

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];
  int                checks;
  int                errors;

  // Monitor: one expected value per clock edge; compare away from the edge.
  always @(negedge clkin) begin
    if (exp_q.size() > 0) begin
      logic [DATA_W-1:0] e;
      string             t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (bus.doutb !== e) begin
        errors++;
        $display("FAIL %s doutb got %02h expected %02h at %0t", t, bus.doutb, e, $time);
      end
    end
  end

  // ---------------- driver ----------------
  // Applies one cycle of inputs, then at the edge records what doutb must
  // become according to the buffer rules and updates the model.
  task automatic cycle(input logic rst, input logic we,
                       input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] di,
                       input logic [ADDR_W-1:0] ab, input string tag);
    rst_n     = rst;
    bus.wea   = we;
    bus.addra = aa;
    bus.dina  = di;
    bus.addrb = ab;
    @(posedge clkin);
    exp_q.push_back(rst ? model_mem[ab] : '0);
    tag_q.push_back(tag);
    if (rst && we) model_mem[aa] = di;
    #1;
  endtask

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'((a ^ (a >> 8)) & 8'hFF);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    rst_n     = 1'b0;
    bus.wea   = 1'b0;
    bus.addra = '0;
    bus.dina  = '0;
    bus.addrb = '0;

    // Reset with a write attempt held active; it must be ignored.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 14'h0010, 8'hFF, 14'h0010, "reset_dout");
    cycle(1'b1, 1'b0, '0, '0, 14'h0010, "reset_blocked_write");

    // Basic write then read.
    cycle(1'b1, 1'b1, 14'h0000, 8'hA5, 14'h0010, "basic_wr");
    cycle(1'b1, 1'b0, '0, '0, 14'h0000, "basic_rd");

    // Address boundaries.
    cycle(1'b1, 1'b1, 14'h3FFF, 8'h5A, 14'h0000, "bound_wr_hi");
    cycle(1'b1, 1'b1, 14'h0000, 8'h11, 14'h3FFF, "bound_rd_hi");
    cycle(1'b1, 1'b0, '0, '0, 14'h0000, "bound_rd_lo");

    // Read-first collision.
    cycle(1'b1, 1'b1, 14'h0123, 8'h22, 14'h0000, "rf_setup");
    cycle(1'b1, 1'b1, 14'h0123, 8'h33, 14'h0123, "rf_old");
    cycle(1'b1, 1'b0, '0, '0, 14'h0123, "rf_new");

    // Write performed on the reset-release cycle.
    cycle(1'b0, 1'b1, 14'h0020, 8'h44, 14'h0020, "rel_in_reset");
    cycle(1'b1, 1'b1, 14'h0020, 8'h77, 14'h0020, "rel_wr");
    cycle(1'b1, 1'b0, '0, '0, 14'h0020, "rel_rd");

    // Streaming fill and read-back with wrap.
    for (int a = 0; a < DEPTH; a++) cycle(1'b1, 1'b1, ADDR_W'(a), pat(a), ADDR_W'(a), "stream_fill");
    for (int a = 0; a <= DEPTH; a++) cycle(1'b1, 1'b0, '0, '0, ADDR_W'(a), "stream_rd");

    // Concurrent ports on disjoint regions.
    for (int i = 0; i < 512; i++)
      cycle(1'b1, 1'b1, ADDR_W'(14'h1000 + i), DATA_W'(i), ADDR_W'(14'h2000 + i), "concurrent");

    // Random traffic over a narrow window to force collisions, with sporadic reset.
    for (int i = 0; i < 3000; i++) begin
      logic              r;
      logic              w;
      logic [ADDR_W-1:0] aa;
      logic [ADDR_W-1:0] ab;
      r  = ($urandom_range(0, 19) != 0);
      w  = $urandom_range(0, 1) == 1;
      aa = ADDR_W'($urandom_range(0, 15)) ^ (($urandom_range(0, 3) == 0) ? 14'h3FF0 : 14'h0000);
      ab = ADDR_W'($urandom_range(0, 15)) ^ (($urandom_range(0, 3) == 0) ? 14'h3FF0 : 14'h0000);
      cycle(r, w, aa, DATA_W'($urandom_range(0, 255)), ab, "random");
    end
    cycle(1'b1, 1'b0, '0, '0, '0, "tail");

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clkin);
    @(negedge clkin);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
